// File: rtl/stream_mux_n.sv
// stream_mux_n: N:1 stream multiplexer, fixed-select or round-robin, registered output.
// Latency: 1 cycle from input accept to out_valid; full throughput of one beat per cycle.
// Backpressure: a stalled output register (out_valid && !out_ready) drops every in_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   mode, sel           0 = channel chosen by sel; 1 = round-robin over valid channels
//   in_data/valid/ready flattened per-channel inputs, channel i = in_data[i*WIDTH +: WIDTH]
//   out_data/valid/ready registered output stream; out_src names the producing channel
// Optional feature (macro STREAM_MUX_LOCK_EN): adds in_last/out_last and holds the
// round-robin grant on one channel until its in_last beat is accepted.
module stream_mux_n #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [NUM_IN-1:0]       in_last,
    output logic                    out_last,
`endif
    output logic [SEL_W-1:0]        out_src
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] rr_next;
    logic             grant_valid;
    logic             load_en;
    logic             accept;
    logic [WIDTH-1:0] grant_data;

`ifdef STREAM_MUX_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
`endif

    // The output register can take a new beat when empty or when it drains this cycle.
    assign load_en = !out_valid || out_ready;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        if (mode == 1'b0) begin
            if (int'(sel) < NUM_IN) begin
                grant       = sel;
                grant_valid = 1'b1;
            end
        end
`ifdef STREAM_MUX_LOCK_EN
        else if (locked) begin
            // Mid-packet: the channel keeps the grant whether or not it is valid right now.
            grant       = lock_ch;
            grant_valid = 1'b1;
        end
`endif
        else begin
            // Scan from farthest to nearest so the valid channel closest to rr_ptr wins last.
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                cand = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
                if (in_valid[cand]) begin
                    grant       = cand;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // in_ready is independent of in_valid so a fixed-select producer can see ready up front.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = !rst && load_en && grant_valid && (grant == SEL_W'(i));
        end
    end

    assign accept  = !rst && load_en && grant_valid && in_valid[grant];
    assign rr_next = (int'(grant) == NUM_IN - 1) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant;
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= in_last[grant];
            if (mode) begin
                if (in_last[grant]) begin
                    locked <= 1'b0;
                    rr_ptr <= rr_next;
                end else begin
                    locked  <= 1'b1;
                    lock_ch <= grant;
                end
            end
`else
            if (mode) begin
                rr_ptr <= rr_next;
            end
`endif
        end else if (load_en) begin
            // Drained with nothing to replace it: data and source keep their last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: directed bench for stream_mux_n with a 4-channel and a 3-channel instance.
// Latency: outputs are checked 1 ns after the rising edge that loads them.
// Backpressure: out_ready is driven directly to exercise stall and release.
module tb_stream_mux_n;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;

    // 4-channel instance
    logic          mode;
    logic [1:0]    sel;
    logic [127:0]  in_data;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_src;
    logic [3:0]    in_last;
    logic          out_last;

    // 3-channel instance
    logic          m3;
    logic [1:0]    s3;
    logic [95:0]   d3;
    logic [2:0]    v3;
    logic [2:0]    rdy3;
    logic [31:0]   od3;
    logic          ov3;
    logic          or3;
    logic [1:0]    os3;
    logic [2:0]    l3;
    logic          ol3;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] D4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    always #5 clk = ~clk;

    stream_mux_n #(.WIDTH(W), .NUM_IN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef STREAM_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_src   (out_src)
    );

    stream_mux_n #(.WIDTH(W), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (m3),
        .sel       (s3),
        .in_data   (d3),
        .in_valid  (v3),
        .in_ready  (rdy3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_ready (or3),
`ifdef STREAM_MUX_LOCK_EN
        .in_last   (l3),
        .out_last  (ol3),
`endif
        .out_src   (os3)
    );

`ifndef STREAM_MUX_LOCK_EN
    assign out_last = 1'b0;
    assign ol3      = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = D4;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        in_last   = 4'hF;
        m3        = 1'b0;
        s3        = 2'd0;
        d3        = {32'h33333333, 32'h22222222, 32'h11111111};
        v3        = 3'b000;
        or3       = 1'b1;
        l3        = 3'b111;

        // Reset with every channel valid: nothing visible, nothing ready.
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_src",   64'(out_src),   64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_out_valid3", 64'(ov3),      64'(0));

        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'h1);
        step();
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("first_data",  64'(out_data),  64'h11111111);
        chk("first_src",   64'(out_src),   64'(0));

        // Fixed-select sweep.
        for (int s = 1; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("sweep_in_ready", 64'(in_ready), 64'(1 << s));
            step();
            chk("sweep_data", 64'(out_data), 64'((s + 1) * 32'h11111111));
            chk("sweep_src",  64'(out_src),  64'(s));
        end

        // Stall three cycles with sel=2, then release with fresh data on ch2.
        sel = 2'd2;
        step();
        chk("pre_stall_data", 64'(out_data), 64'h33333333);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_data",     64'(out_data),  64'h33333333);
            chk("stall_valid",    64'(out_valid), 64'(1));
            chk("stall_in_ready", 64'(in_ready),  64'h0);
        end
        in_data[64 +: 32] = 32'h5A5A5A5A;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'h4);
        step();
        chk("release_data",  64'(out_data),  64'h5A5A5A5A);
        chk("release_valid", 64'(out_valid), 64'(1));
        in_data = D4;

        // Selected channel not valid: ready still shown, output drains, data/src hold.
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        chk("noval_in_ready", 64'(in_ready), 64'h2);
        step();
        chk("noval_valid", 64'(out_valid), 64'(0));
        chk("noval_data",  64'(out_data),  64'h5A5A5A5A);
        chk("noval_src",   64'(out_src),   64'(2));
        in_valid = 4'hF;

        // Round-robin over all channels, rr_ptr untouched by mode 0 so it starts at 0.
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_all_src",  64'(out_src),  64'(i % 4));
            chk("rr_all_data", 64'(out_data), 64'(((i % 4) + 1) * 32'h11111111));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_13_src", 64'(out_src), 64'((i % 2 == 0) ? 1 : 3));
        end
        in_valid = 4'b0000;
        #1;
        chk("rr_none_in_ready", 64'(in_ready), 64'h0);
        step();
        chk("rr_none_valid", 64'(out_valid), 64'(0));
        chk("rr_none_src",   64'(out_src),   64'(3));

`ifdef STREAM_MUX_LOCK_EN
        // ch0 sends a 3-beat packet while ch1 waits; rr_ptr is 0 here.
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        step();
        chk("lock_src_b1",  64'(out_src),  64'(0));
        chk("lock_last_b1", 64'(out_last), 64'(0));
        step();
        chk("lock_src_b2",  64'(out_src),  64'(0));
        chk("lock_last_b2", 64'(out_last), 64'(0));
        in_last = 4'b0001;
        step();
        chk("lock_src_b3",  64'(out_src),  64'(0));
        chk("lock_last_b3", 64'(out_last), 64'(1));
        in_last = 4'b0011;
        step();
        chk("lock_src_b4",  64'(out_src),  64'(1));
        chk("lock_last_b4", 64'(out_last), 64'(1));
        in_last = 4'hF;
`endif

        // Reset while a beat is held under backpressure.
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        step();
        chk("midrst_held_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_valid",    64'(out_valid), 64'(0));
        chk("midrst_data",     64'(out_data),  64'(0));
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready),  64'h0);
        step();
        chk("midrst_in_ready2", 64'(in_ready), 64'h0);
        rst = 1'b0;

        // Three-channel instance: out-of-range select, then round-robin wrap.
        v3 = 3'b111;
        s3 = 2'd2;
        step();
        chk("n3_src2",   64'(os3), 64'(2));
        chk("n3_valid2", 64'(ov3), 64'(1));
        s3 = 2'd3;
        #1;
        chk("n3_sel3_in_ready", 64'(rdy3), 64'h0);
        step();
        chk("n3_sel3_valid", 64'(ov3), 64'(0));
        chk("n3_sel3_src",   64'(os3), 64'(2));
        m3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("n3_rr_src",  64'(os3), 64'(i % 3));
            chk("n3_rr_data", 64'(od3), 64'(((i % 3) + 1) * 32'h11111111));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
